// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch state encoding, NOP word and pc_next_sel constants
package cpu_pkg;
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic PC_SEL_INC = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;
endpackage

// File: rtl/insn_fetch_unit_pc_reg.sv
// pc_reg: program counter with +4 adder, next-pc mux and target alignment check (clk, rst, i_load, i_sel, i_target -> o_pc, o_pc_plus4, o_misalign)
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_sel,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_misalign
);
  logic [31:0] r_pc;
  assign o_pc = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;
  assign o_misalign = (i_sel == PC_SEL_TGT) && (i_target[1:0] != 2'b00);
  always_ff @(posedge clk)
    if (rst) r_pc <= RESET_PC;
    else if (i_load) r_pc <= (i_sel == PC_SEL_TGT) ? i_target : o_pc_plus4;
endmodule

// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: fetches words over mem_req/mem_ack onto INSN, owns pc; optional FETCH_TIMEOUT_EN fault on missing ack (CLK, RST, mem_*, INSN, insn_valid, insn_taken, pc_next_sel, redirect_target, pc, pc_plus4, fetch_fault)
module insn_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] INSN,
  output logic        insn_valid,
  input  logic        insn_taken,
  input  logic        pc_next_sel,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);
  state_t      r_state;
  logic        r_mem_req;
  logic        r_insn_valid;
  logic        r_fault;
  logic [31:0] r_insn;
  logic        w_ack;
  logic        w_take;
  logic        w_misalign;
  logic        w_tmo;
  assign w_ack = (r_state == S_REQ) && r_mem_req && mem_ack;
  assign w_take = (r_state == S_VALID) && r_insn_valid && insn_taken;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign w_tmo = (r_state == S_REQ) && r_mem_req && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge CLK)
    if (RST || r_state != S_REQ) r_cnt <= '0;
    else if (r_mem_req && !mem_ack) r_cnt <= r_cnt + 1'b1;
`else
  assign w_tmo = 1'b0;
`endif
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (CLK),
    .rst       (RST),
    .i_load    (w_take && !w_misalign),
    .i_sel     (pc_next_sel),
    .i_target  (redirect_target),
    .o_pc      (pc),
    .o_pc_plus4(pc_plus4),
    .o_misalign(w_misalign)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      r_state      <= S_REQ;
      r_mem_req    <= 1'b0;
      r_insn_valid <= 1'b0;
      r_insn       <= NOP_INSN;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        S_REQ:
          if (w_ack) begin
            r_insn       <= mem_rdata;
            r_insn_valid <= 1'b1;
            r_mem_req    <= 1'b0;
            r_state      <= S_VALID;
          end else if (w_tmo) begin
            r_fault   <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_FAULT;
          end else r_mem_req <= 1'b1;
        S_VALID:
          if (w_take) begin
            r_insn_valid <= 1'b0;
            r_fault      <= w_misalign;
            r_state      <= w_misalign ? S_FAULT : S_REQ;
          end
        default: begin
          r_mem_req    <= 1'b0;
          r_insn_valid <= 1'b0;
        end
      endcase
    end
  assign mem_req = r_mem_req;
  assign mem_addr = pc;
  assign INSN = r_insn;
  assign insn_valid = r_insn_valid;
  assign fetch_fault = r_fault;
endmodule

// File: tb/tb_insn_fetch_unit.sv
// tb_insn_fetch_unit: directed scoreboard bench for insn_fetch_unit
module tb_insn_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        insn_taken = 1'b0;
  logic        pc_next_sel = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] INSN;
  logic        insn_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
`ifdef FETCH_TIMEOUT_EN
  localparam int WS = 3;
`else
  localparam int WS = 5;
`endif
  always #5 CLK = ~CLK;
  insn_fetch_unit #(
    .RESET_PC(32'h100)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .INSN           (INSN),
    .insn_valid     (insn_valid),
    .insn_taken     (insn_taken),
    .pc_next_sel    (pc_next_sel),
    .redirect_target(redirect_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_fault    (fetch_fault)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int wait_n);
    exp_t e;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge CLK);
    chk("req_seen", {31'b0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, addr);
    for (int i = 0; i < wait_n; i++) begin
      chk("wait_req", {31'b0, mem_req}, 32'd1);
      chk("wait_addr", mem_addr, addr);
      @(negedge CLK);
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    q.push_back('{addr, data});
    chk("valid_before_ack", {31'b0, insn_valid}, 32'd0);
    @(negedge CLK);
    mem_ack = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    chk("valid_after_ack", {31'b0, insn_valid}, 32'd1);
    chk("req_drop", {31'b0, mem_req}, 32'd0);
    chk("sb_nonempty", q.size(), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("insn", INSN, e.data);
      chk("insn_pc", pc, e.addr);
      chk("pc_plus4", pc_plus4, e.addr + 32'd4);
    end
  endtask
  task automatic consume(input logic sel, input logic [31:0] tgt);
    insn_taken = 1'b1;
    pc_next_sel = sel;
    redirect_target = tgt;
    @(negedge CLK);
    insn_taken = 1'b0;
    pc_next_sel = 1'b0;
    redirect_target = 32'h0;
    chk("consume_valid", {31'b0, insn_valid}, 32'd0);
    chk("consume_idle_req", {31'b0, mem_req}, 32'd0);
  endtask
  initial begin
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pc", pc, 32'h100);
    chk("rst_valid", {31'b0, insn_valid}, 32'd0);
    chk("rst_insn", INSN, 32'h13);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h100);
    insn_taken = 1'b1;
    pc_next_sel = 1'b1;
    redirect_target = 32'h3000;
    @(negedge CLK);
    insn_taken = 1'b0;
    pc_next_sel = 1'b0;
    chk("taken_invalid_addr", mem_addr, 32'h100);
    fetch(32'h100, 32'h00B5_0533, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("hold_insn", INSN, 32'h00B5_0533);
      chk("hold_valid", {31'b0, insn_valid}, 32'd1);
      chk("hold_req", {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    consume(1'b0, 32'h0);
    fetch(32'h104, 32'h00B5_0533, WS);
    consume(1'b1, 32'h2000);
    fetch(32'h2000, 32'h1234_5678, 0);
    consume(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0073, 1);
    consume(1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'd0);
    fetch(32'h0, 32'h00A0_0093, 0);
    consume(1'b0, 32'h0);
    @(negedge CLK);
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    RST = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_0001;
    @(negedge CLK);
    RST = 1'b0;
    mem_ack = 1'b0;
    chk("mid_rst_valid", {31'b0, insn_valid}, 32'd0);
    chk("mid_rst_insn", INSN, 32'h13);
    chk("mid_rst_pc", pc, 32'h100);
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    fetch(32'h100, 32'h0040_006F, 0);
    consume(1'b1, 32'h2002);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_pc", pc, 32'h100);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("fault_req", {31'b0, mem_req}, 32'd0);
      chk("fault_valid", {31'b0, insn_valid}, 32'd0);
      chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    mem_ack = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("fault_cleared", {31'b0, fetch_fault}, 32'd0);
`ifdef FETCH_TIMEOUT_EN
    @(negedge CLK);
    chk("tmo_req", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("tmo_not_yet", {31'b0, fetch_fault}, 32'd0);
      @(negedge CLK);
    end
    chk("tmo_last_cycle", {31'b0, fetch_fault}, 32'd0);
    @(negedge CLK);
    chk("tmo_fault", {31'b0, fetch_fault}, 32'd1);
    chk("tmo_req_off", {31'b0, mem_req}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
- Producer side of the 32-bit INSN bus that feeds the instruction decoders. Owns the program counter.
- Requests instruction words from instruction memory over a req/ack handshake and registers the word onto INSN. Holds it valid until the execute stage consumes it.
- Then advances the PC to PC+4, or to a redirect target supplied by the control path (pc_next_sel).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, cycles allowed for mem_ack before a fetch fault (used only with FETCH_TIMEOUT_EN).

Ports:
- CLK  in  1  processor clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  word address of the request; equals pc.
- mem_ack  in  1  memory has driven mem_rdata this cycle.
- mem_rdata  in  32  instruction word from memory.
- INSN  out  32  registered instruction to the decoders.
- insn_valid  out  1  INSN holds a fetched, unconsumed instruction.
- insn_taken  in  1  execute stage consumes INSN this cycle.
- pc_next_sel  in  1  on consume: 0 = PC+4, 1 = redirect_target.
- redirect_target  in  32  branch/jump target from the ALU.
- pc  out  32  address of the instruction currently on INSN.
- pc_plus4  out  32  pc+4, for link-register writes.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous and active-high. Everything samples on the rising edge of CLK.
- Reset values: state = S_REQ, pc = RESET_PC, INSN = 32'h0000_0013 (NOP), insn_valid = 0, mem_req = 0 for the reset cycle, fetch_fault = 0.
- State machine: S_REQ, S_VALID, S_FAULT.
- S_REQ:
  - mem_req = 1, mem_addr = pc, held stable until mem_ack.
  - On mem_ack: INSN <= mem_rdata, insn_valid <= 1, go to S_VALID.
  - mem_ack outside S_REQ is ignored.
- S_VALID:
  - mem_req = 0; INSN and pc are held.
  - On insn_taken with pc_next_sel = 0: pc <= pc+4.
  - On insn_taken with pc_next_sel = 1: pc <= redirect_target.
  - After either update: insn_valid <= 0, go to S_REQ.
  - insn_taken while insn_valid = 0 has no effect.
- Latency: mem_req rises the cycle after entry to S_REQ. insn_valid rises the cycle after mem_ack. One idle cycle separates consume from the next request. Minimum is 3 cycles per instruction with a zero-wait memory.
- Alignment: if a redirect_target has bits [1:0] != 2'b00 at consume, pc is not updated, fetch_fault <= 1, and the unit goes to S_FAULT.
- S_FAULT: mem_req = 0, insn_valid = 0. Exit only by RST.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); wrap is not a fault. pc_plus4 is combinational from pc.
- Simultaneous events: RST has priority over everything. mem_ack and RST together: the word is discarded.
- Reset mid-operation: the next edge returns to reset values regardless of state, with no pending request carried over.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_REQ and increments each S_REQ cycle without mem_ack.
  - When it reaches TIMEOUT, fetch_fault <= 1 and the unit goes to S_FAULT. mem_ack on that same cycle still wins: the fetch completes normally.
  - The counter width is $clog2(TIMEOUT+1).
- Not defined: no counter exists, and S_REQ waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding (S_REQ = 2'd0, S_VALID = 2'd1, S_FAULT = 2'd2);
  - NOP_INSN = 32'h0000_0013;
  - the PC_SEL_INC / PC_SEL_TGT constants, shared with the decoders' pc_next_sel.
- Sub-module: pc_reg, which holds the PC register, the +4 adder, the next-PC mux and the alignment check. Control lives in insn_fetch_unit.

Test Plan:
- Reset behaviour: RST high 2 cycles with RESET_PC = 32'h100 -> pc = 32'h100, insn_valid = 0, INSN = 32'h13, mem_req = 0. mem_req = 1 with mem_addr = 32'h100 the cycle after RST falls.
- Sequential fetch with a zero-wait memory returning 32'h00B50533 (add x10, x10, x11) for every request -> INSN captured, insn_valid = 1. After insn_taken with pc_next_sel = 0, the next mem_addr = 32'h104.
- Wait states: mem_ack delayed 5 cycles -> mem_req and mem_addr stay stable for 5 cycles, and insn_valid rises exactly 1 cycle after mem_ack.
- Redirect, aligned: consume with pc_next_sel = 1, redirect_target = 32'h2000 -> next mem_addr = 32'h2000.
- Redirect, misaligned: redirect_target = 32'h2002 -> fetch_fault = 1, pc unchanged, mem_req stays 0 until RST.
- PC wrap and timeout:
  - pc = 32'hFFFF_FFFC, consume with pc_next_sel = 0 -> pc = 0, no fault.
  - With FETCH_TIMEOUT_EN, TIMEOUT = 4 and no ack -> fetch_fault asserts after 4 request cycles.
